input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable clock cycles required before a button change is accepted (legal range 2..65535).
REQ-002 Parameter SW_WIDTH, default 10, width of the slide-switch bus.
REQ-003 Clk  input  1  single system clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Run  input  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-006 Continue  input  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-007 SW  input  SW_WIDTH  raw asynchronous slide switches.
REQ-008 Run_pulse  output  1  one-cycle strobe, debounced Run press accepted alone.
REQ-009 Continue_pulse  output  1  one-cycle strobe, debounced Continue press accepted alone.
REQ-010 Reset_pulse  output  1  one-cycle strobe, Run+Continue chord detected.
REQ-011 Reset_hold  output  1  level, high while in CHORD state.
REQ-012 SW_s  output  SW_WIDTH  synchronized switches for the downstream processor.

Function
REQ-013 Each of Run, Continue, and every SW bit SHALL pass through a 2-flop synchronizer; SW_s is the second flop with no further filtering.
REQ-014 Per button: pressed_sync = inverted second sync flop; debounced state db and counter cnt (16 bits).
REQ-015 If pressed_sync != db, cnt SHALL increment each edge; when the increment would make cnt equal DEBOUNCE_CYCLES, db SHALL toggle and cnt clear to 0 on that same edge.
REQ-016 If pressed_sync == db, cnt SHALL clear to 0; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change db.
REQ-017 Press latency: raw low first sampled at edge k -> db rises at edge k+1+DEBOUNCE_CYCLES -> strobe high for the cycle following edge k+2+DEBOUNCE_CYCLES; release latency identical.
REQ-018 Chord FSM states IDLE, SINGLE, CHORD, evaluated on db_run and db_cont; all outputs registered.
REQ-019 IDLE: exactly one db rising -> that button's pulse, go SINGLE; both db rising same edge -> Reset_pulse, go CHORD; else stay.
REQ-020 SINGLE: both db high -> Reset_pulse, go CHORD; both db low -> IDLE; else stay, no pulses.
REQ-021 CHORD: Reset_hold = 1; one button released -> stay, no pulses; both db low -> IDLE, Reset_hold low the following cycle.
REQ-022 Run_pulse, Continue_pulse, Reset_pulse SHALL be mutually exclusive and never high two consecutive cycles.
REQ-023 A second press of the same button while the other remains released SHALL require a full release (return to IDLE) before another pulse.

Reset
REQ-024 On Reset: sync flops for Run/Continue = 1 (released), SW sync flops = 0, db = 0, cnt = 0, state = IDLE.
REQ-025 Outputs after Reset: Run_pulse, Continue_pulse, Reset_pulse, Reset_hold, SW_s all 0.
REQ-026 Reset asserted mid-debounce or in CHORD SHALL abort without emitting any pulse; a button held through Reset SHALL be re-debounced and pulse from IDLE.

Structure
REQ-027 Package input_conditioner_pkg SHALL hold the FSM state enum and DEBOUNCE_DEFAULT = 16.
REQ-028 Sub-module button_debouncer (2-flop sync + counter + db, parameterised by DEBOUNCE_CYCLES), instantiated once per button.
REQ-029 Target size 120-400 RTL lines total.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset 2 cycles, Run low from edge 0 held 20 cycles -> Run_pulse high only in cycle after edge 6; no other strobe.
REQ-031 Continue low for 3 cycles then high -> no strobes, db_cont stays 0.
REQ-032 Run and Continue low same edge, held 20 cycles -> single Reset_pulse after edge 6, Reset_hold 1 until both released + debounce, no Run/Continue_pulse.
REQ-033 Run low, Continue low 10 cycles later -> Run_pulse once, then one Reset_pulse; release Run only -> no pulse, Reset_hold stays 1.
REQ-034 SW driven 10'h003 then 10'h004 -> SW_s follows exactly 2 edges later each time.
REQ-035 Reset asserted while Run debouncing (cnt=2) -> no Run_pulse; Run still low after Reset -> Run_pulse 6 edges after Reset deasserts.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the pushbutton/switch input conditioner.
package input_conditioner_pkg;

    // Default number of consecutive stable cycles before a button change is accepted.
    localparam int DEBOUNCE_DEFAULT = 16;

    // Width of the per-button stability counter; covers the full DEBOUNCE_CYCLES range.
    localparam int CNT_WIDTH = 16;

    // Chord detector states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        CHORD  = 2'd2
    } chord_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One active-low pushbutton: 2-flop synchronizer followed by a stability
// counter that flips the debounced "pressed" level only after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic db
);

    localparam logic [CNT_WIDTH-1:0] TARGET = CNT_WIDTH'(DEBOUNCE_CYCLES);

    logic                 sync_meta;
    logic                 sync_out;
    logic                 pressed;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Button is active-low, so the synchronized level is inverted to "pressed".
    assign pressed = ~sync_out;
    assign cnt_inc = cnt + CNT_WIDTH'(1);

    // Synchronize the raw button, then count consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync flops come up as "released" so a reset never fakes a press.
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            db        <= 1'b0;
            cnt       <= '0;
        end else begin
            // NOTE: non-blocking assignments make both sync stages sample their
            // pre-edge inputs, giving a true two-stage delay regardless of order.
            sync_meta <= button;
            sync_out  <= sync_meta;
            if (pressed != db) begin
                if (cnt_inc == TARGET) begin
                    db  <= ~db;
                    cnt <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end else begin
                // Any agreement restarts the window, so short glitches are discarded.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioning for the Run/Continue pushbuttons and slide switches:
// debounces both buttons, turns accepted presses into one-cycle strobes, and
// recognises the Run+Continue chord as a reset request.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SW_WIDTH        = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic                Continue,
    input  logic [SW_WIDTH-1:0] SW,
    output logic                Run_pulse,
    output logic                Continue_pulse,
    output logic                Reset_pulse,
    output logic                Reset_hold,
    output logic [SW_WIDTH-1:0] SW_s
);

    logic                db_run;
    logic                db_cont;
    logic [SW_WIDTH-1:0] sw_meta;

    chord_state_t state;
    chord_state_t state_next;
    logic         run_pulse_next;
    logic         cont_pulse_next;
    logic         reset_pulse_next;
    logic         reset_hold_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk    (Clk),
        .reset  (Reset),
        .button (Run),
        .db     (db_run)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_db (
        .clk    (Clk),
        .reset  (Reset),
        .button (Continue),
        .db     (db_cont)
    );

    // Two-flop synchronizer for the switch bus; no filtering beyond that.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_meta <= '0;
            SW_s    <= '0;
        end else begin
            sw_meta <= SW;
            SW_s    <= sw_meta;
        end
    end

    // Chord FSM state register with registered strobes and hold level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            Run_pulse      <= 1'b0;
            Continue_pulse <= 1'b0;
            Reset_pulse    <= 1'b0;
            Reset_hold     <= 1'b0;
        end else begin
            state          <= state_next;
            Run_pulse      <= run_pulse_next;
            Continue_pulse <= cont_pulse_next;
            Reset_pulse    <= reset_pulse_next;
            Reset_hold     <= reset_hold_next;
        end
    end

    // Next-state and strobe decode. IDLE is only ever held or entered with
    // both debounced buttons low, so a high level seen in IDLE is a rising edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next       = state;
        run_pulse_next   = 1'b0;
        cont_pulse_next  = 1'b0;
        reset_pulse_next = 1'b0;

        case (state)
            IDLE: begin
                if (db_run && db_cont) begin
                    reset_pulse_next = 1'b1;
                    state_next       = CHORD;
                end else if (db_run) begin
                    run_pulse_next = 1'b1;
                    state_next     = SINGLE;
                end else if (db_cont) begin
                    cont_pulse_next = 1'b1;
                    state_next      = SINGLE;
                end
            end
            SINGLE: begin
                if (db_run && db_cont) begin
                    reset_pulse_next = 1'b1;
                    state_next       = CHORD;
                end else if (!db_run && !db_cont) begin
                    state_next = IDLE;
                end
            end
            CHORD: begin
                if (!db_run && !db_cont) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        reset_hold_next = (state_next == CHORD);
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Directed scenarios check hand-derived latencies; a randomized phase compares
// every cycle against a behavioural model built from sample histories.
module tb_input_conditioner;

    localparam int D        = 4;
    localparam int SW_WIDTH = 10;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                Run;
    logic                Continue;
    logic [SW_WIDTH-1:0] SW;
    logic                Run_pulse;
    logic                Continue_pulse;
    logic                Reset_pulse;
    logic                Reset_hold;
    logic [SW_WIDTH-1:0] SW_s;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SW_WIDTH        (SW_WIDTH)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run            (Run),
        .Continue       (Continue),
        .SW             (SW),
        .Run_pulse      (Run_pulse),
        .Continue_pulse (Continue_pulse),
        .Reset_pulse    (Reset_pulse),
        .Reset_hold     (Reset_hold),
        .SW_s           (SW_s)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw samples taken at the last two edges (oldest first); the synchronized
    // level the design acts on at an edge is the raw value from two edges back.
    bit                  run_q[$];
    bit                  cont_q[$];
    logic [SW_WIDTH-1:0] sw_q[$];
    // Recent synchronized "pressed" values; a button's debounced level flips
    // once the last D of them all disagree with it.
    bit                  run_hist[$];
    bit                  cont_hist[$];

    bit                  m_db_run, m_db_cont;
    bit                  m_all_released;   // both debounced levels low at last evaluation
    bit                  m_chord;          // both went high and not yet both released
    bit                  m_rp, m_cp, m_xp, m_hold;
    logic [SW_WIDTH-1:0] m_sw_s;

    function automatic bit all_differ(bit hist[$], bit level);
        if (hist.size() < D) return 1'b0;
        for (int i = hist.size() - D; i < hist.size(); i++)
            if (hist[i] == level) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (Reset) begin
            run_q  = '{1'b1, 1'b1};
            cont_q = '{1'b1, 1'b1};
            sw_q   = '{'0, '0};
            run_hist.delete();
            cont_hist.delete();
            m_db_run = 0; m_db_cont = 0;
            m_all_released = 1; m_chord = 0;
            m_rp = 0; m_cp = 0; m_xp = 0; m_hold = 0;
            m_sw_s = '0;
        end else begin
            bit pr = m_db_run;
            bit pc = m_db_cont;
            // Strobes: a lone button accepted from the fully released condition,
            // or the first moment both buttons are down together.
            m_rp = m_all_released && pr && !pc;
            m_cp = m_all_released && pc && !pr;
            m_xp = !m_chord && pr && pc;
            if (pr && pc) m_chord = 1;
            else if (!pr && !pc) m_chord = 0;
            m_all_released = !pr && !pc;
            m_hold = m_chord;
            // Debounced levels.
            run_hist.push_back(!run_q[0]);
            cont_hist.push_back(!cont_q[0]);
            if (run_hist.size() > D) void'(run_hist.pop_front());
            if (cont_hist.size() > D) void'(cont_hist.pop_front());
            if (all_differ(run_hist, m_db_run)) m_db_run = !m_db_run;
            if (all_differ(cont_hist, m_db_cont)) m_db_cont = !m_db_cont;
            // Switches: value present one edge before this one.
            m_sw_s = sw_q[1];
            run_q.push_back(Run);   void'(run_q.pop_front());
            cont_q.push_back(Continue); void'(cont_q.pop_front());
            sw_q.push_back(SW);     void'(sw_q.pop_front());
        end
    endtask

    // ---------------- cycle driver and event bookkeeping ----------------
    int e = 0;                       // index of the next edge within a scenario
    int n_run, n_cont, n_xp;
    int run_edge, cont_edge, xp_edge, hold_fall;
    bit hold_prev = 0;

    task automatic clear_events();
        n_run = 0; n_cont = 0; n_xp = 0;
        run_edge = -1; cont_edge = -1; xp_edge = -1; hold_fall = -1;
        e = 0;
    endtask

    task automatic tick();
        int this_edge;
        @(posedge Clk);
        this_edge = e;
        e++;
        model_edge();
        @(negedge Clk);
        check("strobes", 32'({Run_pulse, Continue_pulse, Reset_pulse, Reset_hold}),
              32'({m_rp, m_cp, m_xp, m_hold}));
        check("db", 32'({dut.db_run, dut.db_cont}), 32'({m_db_run, m_db_cont}));
        check("sw_s", 32'(SW_s), 32'(m_sw_s));
        if (Run_pulse)      begin n_run++;  run_edge  = this_edge; end
        if (Continue_pulse) begin n_cont++; cont_edge = this_edge; end
        if (Reset_pulse)    begin n_xp++;   xp_edge   = this_edge; end
        if (hold_prev && !Reset_hold) hold_fall = this_edge;
        hold_prev = Reset_hold;
    endtask

    task automatic do_reset();
        Reset = 1; Run = 1; Continue = 1; SW = SW_WIDTH'($urandom);
        repeat (2) tick();
        check("reset_state", 32'({Run_pulse, Continue_pulse, Reset_pulse, Reset_hold, SW_s}), 32'd0);
        Reset = 0;
        clear_events();
    endtask

    initial begin
        int run_left, cont_left;
        Reset = 1; Run = 1; Continue = 1; SW = '0;

        // Lone Run press held 20 cycles.
        do_reset();
        Run = 0;
        repeat (20) tick();
        check("run_count", n_run, 1);
        check("run_edge", run_edge, 6);
        check("run_others", n_cont + n_xp, 0);
        Run = 1;
        repeat (10) tick();

        // Continue glitch one cycle shorter than the debounce window.
        do_reset();
        Continue = 0;
        repeat (D - 1) tick();
        Continue = 1;
        repeat (12) tick();
        check("glitch_strobes", n_run + n_cont + n_xp, 0);
        check("glitch_db", 32'(dut.db_cont), 32'd0);

        // Continue low for exactly the debounce window: accepted.
        do_reset();
        Continue = 0;
        repeat (D) tick();
        Continue = 1;
        repeat (12) tick();
        check("exact_cont_count", n_cont, 1);
        check("exact_cont_edge", cont_edge, 6);

        // Both pressed together, then both released.
        do_reset();
        Run = 0; Continue = 0;
        repeat (20) tick();
        check("chord_count", n_xp, 1);
        check("chord_edge", xp_edge, 6);
        check("chord_singles", n_run + n_cont, 0);
        check("chord_hold", 32'(Reset_hold), 32'd1);
        e = 0;
        Run = 1; Continue = 1;
        repeat (10) tick();
        check("chord_hold_fall", hold_fall, 6);

        // Run first, Continue 10 cycles later, then release Run alone.
        do_reset();
        Run = 0;
        repeat (10) tick();
        Continue = 0;
        repeat (10) tick();
        check("seq_run_edge", run_edge, 6);
        check("seq_xp_edge", xp_edge, 16);
        Run = 1;
        repeat (10) tick();
        check("seq_counts", 32'({8'(n_run), 8'(n_cont), 8'(n_xp)}), 32'h010001);
        check("seq_hold", 32'(Reset_hold), 32'd1);
        Continue = 1;
        repeat (10) tick();
        check("seq_hold_end", 32'(Reset_hold), 32'd0);

        // Switch bus latency.
        do_reset();
        SW = '0;
        repeat (3) tick();
        SW = 10'h003;
        tick();
        check("sw_lag1", 32'(SW_s), 32'h000);
        tick();
        check("sw_003", 32'(SW_s), 32'h003);
        SW = 10'h004;
        tick();
        check("sw_lag2", 32'(SW_s), 32'h003);
        tick();
        check("sw_004", 32'(SW_s), 32'h004);

        // Reset in the middle of a Run debounce, Run kept low throughout.
        do_reset();
        Run = 0;
        repeat (4) tick();
        check("mid_cnt", 32'(dut.u_run_db.cnt), 32'd2);
        Reset = 1;
        repeat (2) tick();
        check("mid_abort", n_run, 0);
        Reset = 0;
        e = 0;
        repeat (10) tick();
        check("mid_run_count", n_run, 1);
        check("mid_run_edge", run_edge, 6);
        Run = 1;
        repeat (10) tick();

        // Randomized phase against the model.
        do_reset();
        run_left = 0; cont_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                Run = ~Run;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 8);
            end
            if (cont_left == 0) begin
                Continue = ~Continue;
                cont_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 8);
            end
            run_left--; cont_left--;
            if ($urandom_range(0, 3) == 0) SW = SW_WIDTH'($urandom);
            Reset = ($urandom_range(0, 299) == 0);
            tick();
            check("exclusive", 32'($countones({Run_pulse, Continue_pulse, Reset_pulse}) <= 1), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
